// File: rtl/block_emitter_pkg.sv
// Shared encodings for block_emitter: ops, FSM states, ASCII bytes.
// Build option: BLOCK_EMITTER_GUARD_EN drops under/overflowing commands.
package block_emitter_pkg;

   typedef enum logic {
      OP_OPEN  = 1'b0,
      OP_CLOSE = 1'b1
   } op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_e;

   localparam logic [7:0] CH_B  = 8'h62;
   localparam logic [7:0] CH_E  = 8'h65;
   localparam logic [7:0] CH_G  = 8'h67;
   localparam logic [7:0] CH_I  = 8'h69;
   localparam logic [7:0] CH_N  = 8'h6E;
   localparam logic [7:0] CH_D  = 8'h64;
   localparam logic [7:0] CH_SP = 8'h20;

   localparam logic [2:0] OPEN_LAST  = 3'd5;
   localparam logic [2:0] CLOSE_LAST = 3'd3;

   function automatic logic [2:0] last_idx(input op_e op);
      return (op == OP_OPEN) ? OPEN_LAST : CLOSE_LAST;
   endfunction

endpackage

// File: rtl/block_emitter_rom.sv
// Token byte table: (op, idx) -> ASCII char, 8'h00 past the token end.
module block_emitter_rom
   import block_emitter_pkg::*;
(
   input  op_e        op_i,
   input  logic [2:0] idx_i,
   output logic [7:0] char_o
);

   always_comb begin
      char_o = 8'h00;
      if (op_i == OP_OPEN) begin
         case (idx_i)
            3'd0:    char_o = CH_B;
            3'd1:    char_o = CH_E;
            3'd2:    char_o = CH_G;
            3'd3:    char_o = CH_I;
            3'd4:    char_o = CH_N;
            3'd5:    char_o = CH_SP;
            default: char_o = 8'h00;
         endcase
      end else begin
         case (idx_i)
            3'd0:    char_o = CH_E;
            3'd1:    char_o = CH_N;
            3'd2:    char_o = CH_D;
            3'd3:    char_o = CH_SP;
            default: char_o = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/block_emitter.sv
// Serializes OPEN/CLOSE commands into "begin "/"end " bytes, tracks depth.
// BLOCK_EMITTER_GUARD_EN: under/overflowing commands are consumed silently.
module block_emitter
   import block_emitter_pkg::*;
#(
   parameter int DEPTH_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_valid,
   input  logic               cmd_op,
   output logic               cmd_ready,
   output logic [7:0]         char_out,
   output logic               char_valid,
   input  logic               char_ready,
   output logic [DEPTH_W-1:0] depth,
   output logic               balanced,
   output logic               err
);

   localparam logic [DEPTH_W-1:0] ONE = DEPTH_W'(1);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [2:0]         idx_q, idx_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               err_q, err_d;

   logic               cmd_acc;
   logic               byte_acc;
   logic               bad;
   logic [DEPTH_W-1:0] depth_nxt;
   logic [7:0]         rom_char;

   assign cmd_ready  = (state_q == S_IDLE);
   assign char_valid = (state_q == S_EMIT);
   assign cmd_acc    = cmd_valid && cmd_ready;
   assign byte_acc   = char_valid && char_ready;

   assign bad = cmd_acc &&
                (((cmd_op == OP_CLOSE) && (depth_q == '0)) ||
                 ((cmd_op == OP_OPEN)  && (depth_q == '1)));

   assign depth_nxt = (cmd_op == OP_OPEN) ? depth_q + ONE
                                          : depth_q - ONE;

   block_emitter_rom u_rom (
      .op_i   (op_q),
      .idx_i  (idx_q),
      .char_o (rom_char)
   );

   // Idle latched op/idx would otherwise present a stale byte.
   assign char_out = char_valid ? rom_char : 8'h00;
   assign depth    = depth_q;
   assign err      = err_q;
   assign balanced = (depth_q == '0) && (state_q == S_IDLE) && !err_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      depth_d = depth_q;
      err_d   = err_q | bad;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_acc) begin
`ifdef BLOCK_EMITTER_GUARD_EN
               if (!bad) begin
                  state_d = S_EMIT;
                  op_d    = op_e'(cmd_op);
                  idx_d   = 3'd0;
                  depth_d = depth_nxt;
               end
`else
               state_d = S_EMIT;
               op_d    = op_e'(cmd_op);
               idx_d   = 3'd0;
               depth_d = depth_nxt;
`endif
            end
         end
         S_EMIT: begin
            if (byte_acc) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == last_idx(op_q)) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_OPEN;
         idx_q   <= 3'd0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/block_emitter.md
# block_emitter

Generates the space-delimited, lower-case `begin`/`end` character stream that the block-structure checker consumes. The block accepts one abstract command per handshake (open block or close block), serializes it into ASCII bytes one per cycle over a valid/ready byte interface, and tracks nesting depth. It sits upstream of the checker in test harnesses and in the text-generation path. It also reports whether the stream emitted so far is balanced.

## Interface
- `DEPTH_W`, default 8: width of the nesting-depth counter.
- `clk  in  1`: clock; all state changes on its rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `cmd_valid  in  1`: command present.
- `cmd_op  in  1`: 0 = OPEN (emit `begin `), 1 = CLOSE (emit `end `).
- `cmd_ready  out  1`: block can accept a command.
- `char_out  out  8`: ASCII byte.
- `char_valid  out  1`: `char_out` is valid.
- `char_ready  in  1`: downstream accepts the byte.
- `depth  out  DEPTH_W`: current nesting depth, counted over accepted commands.
- `balanced  out  1`: high when `depth == 0`, state is IDLE and `err == 0`.
- `err  out  1`: sticky error flag; only reset clears it.

## Operation
- FSM states are IDLE and EMIT.
- In IDLE, `cmd_ready = 1` and `char_valid = 0`.
- In EMIT, `cmd_ready = 0` and `char_valid = 1`.
- Command accept: `cmd_valid && cmd_ready`. On accept the block latches `op`, clears index `idx` (3 bits), updates `depth` (+1 on OPEN, −1 on CLOSE) and goes to EMIT.
- Byte sequences:
  - OPEN: `b e g i n ' '`, 6 bytes, last `idx = 5`.
  - CLOSE: `e n d ' '`, 4 bytes, last `idx = 3`.
- `char_out` is a pure function of latched `op` and `idx`.
- Byte accept: `char_valid && char_ready`. On accept, `idx` increments. Accepting the last byte returns the FSM to IDLE.
- Without byte accept, `char_out` and `idx` hold, so backpressure is honoured for any number of cycles.
- Underflow: CLOSE accepted at `depth == 0`. This sets `err`.
- Overflow: OPEN accepted at `depth == 2^DEPTH_W − 1`. This sets `err`.
- Reset values:
  - State IDLE; `idx = 0`; `depth = 0`; `err = 0`.
  - `char_valid = 0`; `char_out = 8'h00`; `cmd_ready = 1`; `balanced = 1`.
- Reset mid-emission abandons the partial token immediately. No further bytes of it appear after release.

## Timing
- Command accepted at edge N: first byte is valid from N until accepted; `depth` reflects the command after edge N.
- With `char_ready` held high:
  - OPEN occupies 1 accept cycle plus 6 byte cycles.
  - CLOSE occupies 1 accept cycle plus 4 byte cycles.
  - `cmd_ready` returns high the cycle after the last byte is accepted.
- No back-to-back overlap: a new command is never accepted in the same cycle as a last-byte accept.
- `err` rises in the cycle after the offending accept edge and stays high.
- `balanced` is combinational from registered state.

## Configuration
- Macro: `BLOCK_EMITTER_GUARD_EN`.
- Defined:
  - An underflowing CLOSE or overflowing OPEN is consumed (handshake completes), sets `err`, and emits nothing.
  - `depth` is unchanged and the FSM stays in IDLE, with `cmd_ready` high the next cycle.
- Undefined:
  - The offending command is emitted normally and `err` is still set.
  - `depth` wraps modulo `2^DEPTH_W`. This lets benches produce malformed streams for the checker.

## Structure
- Package `block_emitter_pkg` holds:
  - the op encoding `OP_OPEN` / `OP_CLOSE`;
  - the state enum;
  - ASCII constants `CH_B`, `CH_E`, `CH_G`, `CH_I`, `CH_N`, `CH_D`, `CH_SP`;
  - last-index constants `OPEN_LAST = 5` and `CLOSE_LAST = 3`.
- One sub-module, `block_emitter_rom`: combinational `(op, idx) -> char`. It returns `8'h00` for out-of-range `idx`.

## Test plan
- Reset, then OPEN with `char_ready` held high:
  - bytes are 62 65 67 69 6E 20 on consecutive cycles;
  - `depth = 1`, `balanced = 0`, `err = 0`.
- OPEN, then CLOSE:
  - stream is `begin end `;
  - final `depth = 0`, `balanced = 1`, and `cmd_ready` is low for exactly 6 and then 4 cycles after each accept.
- OPEN with `char_ready` low for 3 cycles on byte `g`: `char_out` holds at 67 for those cycles, then the sequence continues unchanged.
- CLOSE at `depth 0`:
  - with guard: no `char_valid`, `err = 1`, `depth = 0`;
  - without guard: 65 6E 64 20 emitted, `err = 1`, `depth = 255` (`DEPTH_W = 8`).
- `reset_n` asserted low while on byte `i` of an OPEN: outputs take reset values immediately, and after release a CLOSE emits only 65 6E 64 20.
- `DEPTH_W = 2`, OPEN three times then a fourth OPEN: the fourth OPEN sets `err`; with guard, `depth` stays at 3 and no bytes are emitted.
